// File: rtl/mips_soc.sv
// mips_soc: minimal single-cycle MIPS-I system.
//   mips_soc  : top level with clk and reset (synchronous, active-low) only.
//   mips_core : single-cycle datapath. Fetches from imem, accesses dmem and
//               keeps a retire trace (MEM_current_pc / MEM_current_instr).
//   mips_gpr  : 32x32 register file with two async read ports and one sync
//               write port. $0 is never written.
//   mips_imem : 1024-word instruction ROM with async read, indexed by PC[11:2].
//   mips_dmem : 2048-word data RAM plus the ANSCODE register at 0x2000.
//               Async read, write on the clock edge.

module mips_gpr (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] array_reg [0:31];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) array_reg[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            array_reg[waddr] <= wdata;
        end
    end

    // Entry 0 is cleared by reset and never written, so it always reads 0.
    assign rdata1 = array_reg[raddr1];
    assign rdata2 = array_reg[raddr2];
endmodule

module mips_imem (
    input  logic [9:0]  addr,
    output logic [31:0] data
);
    logic [31:0] inst_array [0:1023];

    assign data = inst_array[addr];
endmodule

module mips_dmem (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [29:0] addr,      // word address: byte address [31:2]
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] data_array [0:2047];
    logic [31:0] ANSCODE_reg;
    logic        in_ram;
    logic        is_ans;

    assign in_ram = (addr[29:11] == '0);
    assign is_ans = (addr == 30'h800);

    always_ff @(posedge clk) begin
        if (reset && we && in_ram) data_array[addr[10:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset)               ANSCODE_reg <= '0;
        else if (we && is_ans)    ANSCODE_reg <= wdata;
    end

    assign rdata = in_ram ? data_array[addr[10:0]] :
                   is_ans ? ANSCODE_reg : '0;
endmodule

module mips_core (
    input  logic        clk,
    input  logic        reset,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic [29:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_we,
    input  logic [31:0] dmem_rdata
);
    logic [31:0] pc, pc4, next_pc, instr;
    logic [31:0] MEM_current_pc, MEM_current_instr;
    logic [31:0] rs_val, rt_val, simm, zimm, mem_addr;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        unused_lo;

    assign instr = imem_data;
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign sh    = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];
    assign simm  = {{16{imm[15]}}, imm};
    assign zimm  = {16'h0000, imm};
    assign pc4   = pc + 32'd4;

    assign imem_addr  = pc[11:2];
    assign mem_addr   = rs_val + simm;
    assign dmem_addr  = mem_addr[31:2];
    assign dmem_wdata = rt_val;
    assign unused_lo  = &{1'b0, mem_addr[1:0]};

    mips_gpr gpr_inst (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rs_val),
        .rdata2 (rt_val),
        .we     (wr_en),
        .waddr  (wr_addr),
        .wdata  (wr_data)
    );

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rt;
        wr_data = '0;
        dmem_we = 1'b0;
        next_pc = pc4;
        case (op)
            6'h00: begin
                wr_addr = rd;
                wr_en   = 1'b1;
                case (funct)
                    6'h20, 6'h21: wr_data = rs_val + rt_val;
                    6'h23:        wr_data = rs_val - rt_val;
                    6'h24:        wr_data = rs_val & rt_val;
                    6'h25:        wr_data = rs_val | rt_val;
                    6'h26:        wr_data = rs_val ^ rt_val;
                    6'h27:        wr_data = ~(rs_val | rt_val);
                    6'h2a:        wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    6'h2b:        wr_data = {31'd0, rs_val < rt_val};
                    6'h00:        wr_data = rt_val << sh;
                    6'h02:        wr_data = rt_val >> sh;
                    6'h03:        wr_data = $signed(rt_val) >>> sh;
                    6'h08: begin
                        wr_en   = 1'b0;
                        next_pc = rs_val;
                    end
                    default:      wr_en = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin wr_en = 1'b1; wr_data = rs_val + simm; end
            6'h0a: begin wr_en = 1'b1; wr_data = {31'd0, $signed(rs_val) < $signed(simm)}; end
            6'h0b: begin wr_en = 1'b1; wr_data = {31'd0, rs_val < simm}; end
            6'h0c: begin wr_en = 1'b1; wr_data = rs_val & zimm; end
            6'h0d: begin wr_en = 1'b1; wr_data = rs_val | zimm; end
            6'h0e: begin wr_en = 1'b1; wr_data = rs_val ^ zimm; end
            6'h0f: begin wr_en = 1'b1; wr_data = {imm, 16'h0000}; end
            6'h23: begin wr_en = 1'b1; wr_data = dmem_rdata; end
            6'h2b: dmem_we = 1'b1;
            6'h04: if (rs_val == rt_val) next_pc = pc4 + {simm[29:0], 2'b00};
            6'h05: if (rs_val != rt_val) next_pc = pc4 + {simm[29:0], 2'b00};
            6'h02: next_pc = {pc4[31:28], instr[25:0], 2'b00};
            6'h03: begin
                next_pc = {pc4[31:28], instr[25:0], 2'b00};
                wr_en   = 1'b1;
                wr_addr = 5'd31;
                wr_data = pc4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc                <= '0;
            MEM_current_pc    <= '0;
            MEM_current_instr <= '0;
        end else begin
            pc                <= next_pc;
            MEM_current_pc    <= pc;
            MEM_current_instr <= instr;
        end
    end
endmodule

module mips_soc (
    input  logic clk,
    input  logic reset
);
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [29:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_we;

    mips_core core0 (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata)
    );

    mips_imem imem_inst (
        .addr (imem_addr),
        .data (imem_data)
    );

    mips_dmem dmem_inst (
        .clk   (clk),
        .reset (reset),
        .we    (dmem_we),
        .addr  (dmem_addr),
        .wdata (dmem_wdata),
        .rdata (dmem_rdata)
    );
endmodule

// File: tb/tb_mips_soc.sv
// Self-checking bench for mips_soc: reset behaviour, a directed program with
// a table of expected final state and an expected retire-PC sequence, a
// mid-run reset, and a random program compared cycle by cycle against an
// instruction-level reference model.
module tb_mips_soc;
    logic clk = 1'b0;
    logic reset = 1'b0;

    mips_soc dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_imem [1024];
    logic [31:0] m_mem  [2048];
    logic [31:0] m_reg  [32];
    logic [31:0] m_ans, m_pc, m_tr_pc, m_tr_ins;

    typedef struct {
        string       name;
        int          kind;   // 0 = GPR, 1 = dmem word, 2 = ANSCODE
        int          idx;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [16];

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        logic [31:0] w;
        w = 32'd0;
        w[25:21] = rs[4:0]; w[20:16] = rt[4:0]; w[15:11] = rd[4:0];
        w[10:6] = sh[4:0]; w[5:0] = fn[5:0];
        return w;
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        logic [31:0] w;
        w = 32'd0;
        w[31:26] = op[5:0]; w[25:21] = rs[4:0]; w[20:16] = rt[4:0]; w[15:0] = imm[15:0];
        return w;
    endfunction

    function automatic logic [31:0] enc_j(int op, int idx);
        logic [31:0] w;
        w = 32'd0;
        w[31:26] = op[5:0]; w[25:0] = idx[25:0];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic load_prog(input logic [31:0] p [1024]);
        for (int i = 0; i < 1024; i++) begin
            dut.imem_inst.inst_array[i] = p[i];
            m_imem[i] = p[i];
        end
    endtask

    task automatic check_all_regs_zero(string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_reg%0d", tag, i), dut.core0.gpr_inst.array_reg[i], 32'd0);
    endtask

    // ---------------- behavioural ISA model ----------------
    function automatic logic [31:0] m_load(logic [31:0] a);
        if (a < 32'h2000) return m_mem[a / 4];
        if ((a & ~32'd3) == 32'h2000) return m_ans;
        return 32'd0;
    endfunction

    task automatic m_store(logic [31:0] a, logic [31:0] v);
        if (a < 32'h2000) m_mem[a / 4] = v;
        else if ((a & ~32'd3) == 32'h2000) m_ans = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_pc = 32'd0; m_ans = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, se, ze, pc4, nxt, wv;
        int dst;
        ins = m_imem[(m_pc / 4) % 1024];
        m_tr_pc = m_pc; m_tr_ins = ins;
        a = m_reg[ins[25:21]]; b = m_reg[ins[20:16]];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'd0, ins[15:0]};
        pc4 = m_pc + 4; nxt = pc4; dst = -1; wv = 32'd0;
        case (ins[31:26])
            6'h00: begin
                dst = ins[15:11];
                case (ins[5:0])
                    6'h20, 6'h21: wv = a + b;
                    6'h23: wv = a - b;
                    6'h24: wv = a & b;
                    6'h25: wv = a | b;
                    6'h26: wv = a ^ b;
                    6'h27: wv = ~(a | b);
                    6'h2a: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2b: wv = (a < b) ? 32'd1 : 32'd0;
                    6'h00: wv = b << ins[10:6];
                    6'h02: wv = b >> ins[10:6];
                    6'h03: wv = $signed(b) >>> ins[10:6];
                    6'h08: begin dst = -1; nxt = a; end
                    default: dst = -1;
                endcase
            end
            6'h08, 6'h09: begin dst = ins[20:16]; wv = a + se; end
            6'h0a: begin dst = ins[20:16]; wv = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
            6'h0b: begin dst = ins[20:16]; wv = (a < se) ? 32'd1 : 32'd0; end
            6'h0c: begin dst = ins[20:16]; wv = a & ze; end
            6'h0d: begin dst = ins[20:16]; wv = a | ze; end
            6'h0e: begin dst = ins[20:16]; wv = a ^ ze; end
            6'h0f: begin dst = ins[20:16]; wv = ze * 65536; end
            6'h23: begin dst = ins[20:16]; wv = m_load(a + se); end
            6'h2b: m_store(a + se, b);
            6'h04: if (a == b) nxt = pc4 + se * 4;
            6'h05: if (a != b) nxt = pc4 + se * 4;
            6'h02: nxt = (pc4 & 32'hF000_0000) + ins[25:0] * 4;
            6'h03: begin nxt = (pc4 & 32'hF000_0000) + ins[25:0] * 4; dst = 31; wv = pc4; end
            default: ;
        endcase
        if (dst > 0) m_reg[dst] = wv;
        m_pc = nxt;
    endtask

    function automatic int mem_off();
        int k, lo;
        k = $urandom_range(0, 18);
        lo = $urandom_range(0, 3);
        if (k < 16) return k * 4 + lo;
        return 32'h2000 + (k - 16) * 4 + lo;
    endfunction

    function automatic logic [31:0] rand_instr();
        int rs, rt, rd, sh, imm, k;
        rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
        rd = $urandom_range(0, 31); sh = $urandom_range(0, 31);
        imm = $urandom_range(0, 65535);
        k = $urandom_range(0, 28);
        case (k)
            0:  return enc_r(rs, rt, rd, 0, 'h21);
            1:  return enc_r(rs, rt, rd, 0, 'h20);
            2:  return enc_r(rs, rt, rd, 0, 'h23);
            3:  return enc_r(rs, rt, rd, 0, 'h24);
            4:  return enc_r(rs, rt, rd, 0, 'h25);
            5:  return enc_r(rs, rt, rd, 0, 'h26);
            6:  return enc_r(rs, rt, rd, 0, 'h27);
            7:  return enc_r(rs, rt, rd, 0, 'h2a);
            8:  return enc_r(rs, rt, rd, 0, 'h2b);
            9:  return enc_r(0, rt, rd, sh, 'h00);
            10: return enc_r(0, rt, rd, sh, 'h02);
            11: return enc_r(0, rt, rd, sh, 'h03);
            12: return enc_r(rs, 0, 0, 0, 'h08);
            13: return enc_i('h09, rs, rt, imm);
            14: return enc_i('h08, rs, rt, imm);
            15: return enc_i('h0c, rs, rt, imm);
            16: return enc_i('h0d, rs, rt, imm);
            17: return enc_i('h0e, rs, rt, imm);
            18: return enc_i('h0f, 0, rt, imm);
            19: return enc_i('h0a, rs, rt, imm);
            20: return enc_i('h0b, rs, rt, imm);
            21: return enc_i('h23, 0, rt, mem_off());
            22: return enc_i('h2b, (imm % 2 == 0) ? 0 : rs, rt, mem_off());
            23: return enc_i('h04, rs, rt, $urandom_range(0, 16) - 8);
            24: return enc_i('h05, rs, rt, $urandom_range(0, 16) - 8);
            25: return enc_j('h02, $urandom_range(0, 1023));
            26: return enc_j('h03, $urandom_range(0, 1023));
            27: return enc_r(rs, rt, rd, 0, 'h22);
            default: return enc_i('h20, rs, rt, imm);
        endcase
    endfunction

    logic [31:0] prog [1024];
    int seq [30];

    initial begin
        // ---------- reset and setup program ----------
        for (int i = 0; i < 1024; i++) prog[i] = 32'd0;
        prog[0] = enc_i('h09, 0, 1, 'h0a0a);
        prog[1] = enc_i('h2b, 0, 1, 0);
        prog[2] = enc_i('h09, 0, 1, 'h0b0b);
        prog[3] = enc_i('h2b, 0, 1, 4);
        prog[4] = enc_j('h02, 4);
        load_prog(prog);
        reset = 1'b0;
        tick(); tick();
        check("rst_pc", dut.core0.pc, 32'd0);
        check("rst_ans", dut.dmem_inst.ANSCODE_reg, 32'd0);
        check("rst_trace_pc", dut.core0.MEM_current_pc, 32'd0);
        check("rst_trace_instr", dut.core0.MEM_current_instr, 32'd0);
        check_all_regs_zero("rst");
        reset = 1'b1;
        tick();
        check("first_trace_pc", dut.core0.MEM_current_pc, 32'd0);
        check("first_trace_instr", dut.core0.MEM_current_instr, enc_i('h09, 0, 1, 'h0a0a));
        for (int i = 0; i < 6; i++) tick();
        check("setup_dmem0", dut.dmem_inst.data_array[0], 32'h0a0a);
        check("setup_dmem1", dut.dmem_inst.data_array[1], 32'h0b0b);

        // ---------- directed program ----------
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) prog[i] = 32'd0;
        prog['h00/4] = enc_i('h0f, 0, 1, 'h1234);
        prog['h04/4] = enc_i('h0d, 1, 1, 'h5678);
        prog['h08/4] = enc_i('h09, 0, 2, 'hffff);
        prog['h0c/4] = enc_r(1, 2, 3, 0, 'h21);
        prog['h10/4] = enc_j('h03, 7);
        prog['h14/4] = enc_r(1, 2, 4, 0, 'h2b);
        prog['h18/4] = enc_j('h02, 9);
        prog['h1c/4] = enc_i('h09, 0, 0, 5);
        prog['h20/4] = enc_r(31, 0, 0, 0, 'h08);
        prog['h24/4] = enc_i('h2b, 0, 1, 8);
        prog['h28/4] = enc_i('h23, 0, 5, 8);
        prog['h2c/4] = enc_i('h2b, 0, 1, 'h2000);
        prog['h30/4] = enc_i('h04, 0, 0, 1);
        prog['h34/4] = enc_i('h09, 0, 7, 'h99);
        prog['h38/4] = enc_i('h09, 0, 6, 3);
        prog['h3c/4] = enc_i('h09, 8, 8, 1);
        prog['h40/4] = enc_i('h09, 6, 6, 'hffff);
        prog['h44/4] = enc_i('h05, 6, 0, 'hfffd);
        prog['h48/4] = enc_i('h23, 0, 9, 'h2000);
        prog['h4c/4] = enc_i('h23, 0, 10, 'h2004);
        prog['h50/4] = enc_i('h2b, 0, 1, 'h2004);
        prog['h54/4] = enc_j('h02, 'h15);
        load_prog(prog);
        seq = '{'h00, 'h04, 'h08, 'h0c, 'h10, 'h1c, 'h20, 'h14, 'h18, 'h24,
                'h28, 'h2c, 'h30, 'h38, 'h3c, 'h40, 'h44, 'h3c, 'h40, 'h44,
                'h3c, 'h40, 'h44, 'h48, 'h4c, 'h50, 'h54, 'h54, 'h54, 'h54};
        tick();
        reset = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            check($sformatf("trace_pc_%0d", c), dut.core0.MEM_current_pc, seq[c]);
            if (c == 10) check("ans_before_sw", dut.dmem_inst.ANSCODE_reg, 32'd0);
            if (c == 11) begin
                check("ans_after_sw", dut.dmem_inst.ANSCODE_reg, 32'h12345678);
                check("ans_sw_dmem0", dut.dmem_inst.data_array[0], 32'h0a0a);
            end
        end

        tbl[0]  = '{"r1_lui_ori", 0, 1, 32'h12345678};
        tbl[1]  = '{"r2_addiu_neg", 0, 2, 32'hffffffff};
        tbl[2]  = '{"r3_addu", 0, 3, 32'h12345677};
        tbl[3]  = '{"r4_sltu", 0, 4, 32'd1};
        tbl[4]  = '{"r0_const", 0, 0, 32'd0};
        tbl[5]  = '{"r5_lw", 0, 5, 32'h12345678};
        tbl[6]  = '{"r31_jal", 0, 31, 32'h14};
        tbl[7]  = '{"r6_loop_end", 0, 6, 32'd0};
        tbl[8]  = '{"r7_skipped", 0, 7, 32'd0};
        tbl[9]  = '{"r8_loop_count", 0, 8, 32'd3};
        tbl[10] = '{"r9_lw_ans", 0, 9, 32'h12345678};
        tbl[11] = '{"r10_lw_unmapped", 0, 10, 32'd0};
        tbl[12] = '{"dmem2_sw", 1, 2, 32'h12345678};
        tbl[13] = '{"dmem0_kept", 1, 0, 32'h0a0a};
        tbl[14] = '{"dmem1_unmapped_sw", 1, 1, 32'h0b0b};
        tbl[15] = '{"anscode", 2, 0, 32'h12345678};
        for (int i = 0; i < 16; i++) begin
            case (tbl[i].kind)
                0: check(tbl[i].name, dut.core0.gpr_inst.array_reg[tbl[i].idx], tbl[i].exp);
                1: check(tbl[i].name, dut.dmem_inst.data_array[tbl[i].idx], tbl[i].exp);
                default: check(tbl[i].name, dut.dmem_inst.ANSCODE_reg, tbl[i].exp);
            endcase
        end

        // ---------- mid-run reset ----------
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        check("mid_trace_pc19", dut.core0.MEM_current_pc, seq[19]);
        reset = 1'b0;
        tick();
        check_all_regs_zero("mid");
        check("mid_pc", dut.core0.pc, 32'd0);
        check("mid_ans", dut.dmem_inst.ANSCODE_reg, 32'd0);
        check("mid_trace_pc", dut.core0.MEM_current_pc, 32'd0);
        check("mid_dmem2_kept", dut.dmem_inst.data_array[2], 32'h12345678);
        check("mid_imem0_kept", dut.imem_inst.inst_array[0], enc_i('h0f, 0, 1, 'h1234));
        reset = 1'b1;
        tick();
        check("mid_restart_pc", dut.core0.MEM_current_pc, 32'd0);
        check("mid_restart_instr", dut.core0.MEM_current_instr, enc_i('h0f, 0, 1, 'h1234));

        // ---------- random program vs. reference model ----------
        reset = 1'b0;
        for (int i = 0; i < 16; i++) prog[i] = enc_i('h2b, 0, 0, i * 4);
        for (int i = 16; i < 1024; i++) prog[i] = rand_instr();
        load_prog(prog);
        for (int i = 0; i < 2048; i++) m_mem[i] = 32'd0;
        model_reset();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            model_step();
            tick();
            check($sformatf("rnd%0d_pc", c), dut.core0.MEM_current_pc, m_tr_pc);
            check($sformatf("rnd%0d_instr", c), dut.core0.MEM_current_instr, m_tr_ins);
            check($sformatf("rnd%0d_ans", c), dut.dmem_inst.ANSCODE_reg, m_ans);
            for (int r = 0; r < 32; r++)
                check($sformatf("rnd%0d_reg%0d", c, r), dut.core0.gpr_inst.array_reg[r], m_reg[r]);
            if (n_bad > 20) break;
        end
        for (int i = 0; i < 16; i++)
            check($sformatf("rnd_dmem%0d", i), dut.dmem_inst.data_array[i], m_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
